sub9bit_core: RTL and testbench

SUB9BIT_CORE -- requirements
Module: sub9bit

---
 rtl/sub9bit_core.sv | 61 ++++++
 tb/tb_sub9bit_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sub9bit_core.sv
// Registered 9-bit adder/subtractor with carry-out and signed-overflow flag; optional saturation under SUB9BIT_SAT_EN.
// Latency: one clk cycle from input sample to registered S/CO/OFL.
// Backpressure: none; a new operation is accepted on every rising edge.
module sub9bit_core #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             ADD,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OFL
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   raw;
    logic             ofl_raw;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             co_d;
    logic             co_q;
    logic             ofl_d;
    logic             ofl_q;

    // Subtract is A + ~B + CI, so CI=1 means "no borrow-in" and CO=1 means "no borrow".
    assign b_eff   = ADD ? B : ~B;
    assign raw     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, CI};
    assign ofl_raw = (A[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        co_d  = raw[WIDTH];
        ofl_d = ofl_raw;
        s_d   = raw[WIDTH-1:0];
`ifdef SUB9BIT_SAT_EN
        // Clamp toward the operands' common sign; CO/OFL still report the raw result.
        if (ofl_raw) begin
            s_d = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            ofl_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            co_q  <= co_d;
            ofl_q <= ofl_d;
        end
    end

    assign S   = s_q;
    assign CO  = co_q;
    assign OFL = ofl_q;

endmodule

// File: tb/tb_sub9bit_core.sv
// Bench for sub9bit_core: directed corner cases, reset behaviour and randomized back-to-back operations
// compared against an integer-arithmetic reference model.
module tb_sub9bit_core;

    logic       clk;
    logic       rst_n;
    logic [8:0] A;
    logic [8:0] B;
    logic       CI;
    logic       ADD;
    logic [8:0] S;
    logic       CO;
    logic       OFL;

    int n_cmp;
    int n_err;

    sub9bit_core #(.WIDTH(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .CI    (CI),
        .ADD   (ADD),
        .S     (S),
        .CO    (CO),
        .OFL   (OFL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer results, then reduced to the 9-bit view.
    task automatic model(input logic [8:0] a, input logic [8:0] b, input logic ci, input logic add,
                         output logic [8:0] s, output logic co, output logic ofl);
        int ua;
        int ub;
        int sa;
        int sb;
        int tu;
        int ts;
        ua = int'(a);
        ub = int'(b);
        sa = a[8] ? ua - 512 : ua;
        sb = b[8] ? ub - 512 : ub;
        if (add) begin
            tu = ua + ub + int'(ci);
            ts = sa + sb + int'(ci);
            co = (tu >= 512);
        end else begin
            tu = ua - ub - (ci ? 0 : 1);
            ts = sa - sb - (ci ? 0 : 1);
            co = (tu >= 0);
        end
        ofl = (ts > 255) || (ts < -256);
        s   = 9'((tu + 1024) % 512);
`ifdef SUB9BIT_SAT_EN
        if (ofl) s = (ts > 255) ? 9'h0FF : 9'h100;
`endif
    endtask

    // Called at a negedge: drive, then check one cycle later at the next negedge.
    task automatic run_op(input string tag, input logic [8:0] a, input logic [8:0] b,
                          input logic ci, input logic add);
        logic [8:0] es;
        logic       eco;
        logic       eofl;
        A = a; B = b; CI = ci; ADD = add;
        model(a, b, ci, add, es, eco, eofl);
        @(negedge clk);
        check({tag, ".S"},   32'(S),   32'(es));
        check({tag, ".CO"},  32'(CO),  32'(eco));
        check({tag, ".OFL"}, 32'(OFL), 32'(eofl));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        A = 9'h0AB; B = 9'h123; CI = 1'b1; ADD = 1'b1;
        #2;
        check("rst.S", 32'(S), 32'h0);
        check("rst.CO", 32'(CO), 32'h0);
        check("rst.OFL", 32'(OFL), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk.S", 32'(S), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spec-given corner cases, with literal expected values.
        A = 9'd23; B = 9'd80; CI = 1'b1; ADD = 1'b0;
        @(negedge clk);
        check("sub57.S", 32'(S), 32'h1C7);
        check("sub57.CO", 32'(CO), 32'h0);
        check("sub57.OFL", 32'(OFL), 32'h0);
        A = 9'd23; B = 9'd80; CI = 1'b0; ADD = 1'b1;
        @(negedge clk);
        check("add103.S", 32'(S), 32'h067);
        check("add103.CO", 32'(CO), 32'h0);
        check("add103.OFL", 32'(OFL), 32'h0);
        A = 9'h0FF; B = 9'h001; CI = 1'b0; ADD = 1'b1;
        @(negedge clk);
`ifdef SUB9BIT_SAT_EN
        check("addovf.S", 32'(S), 32'h0FF);
`else
        check("addovf.S", 32'(S), 32'h100);
`endif
        check("addovf.CO", 32'(CO), 32'h0);
        check("addovf.OFL", 32'(OFL), 32'h1);
        A = 9'h100; B = 9'h001; CI = 1'b1; ADD = 1'b0;
        @(negedge clk);
`ifdef SUB9BIT_SAT_EN
        check("subovf.S", 32'(S), 32'h100);
`else
        check("subovf.S", 32'(S), 32'h0FF);
`endif
        check("subovf.CO", 32'(CO), 32'h1);
        check("subovf.OFL", 32'(OFL), 32'h1);
        A = 9'h000; B = 9'h000; CI = 1'b0; ADD = 1'b0;
        @(negedge clk);
        check("bin0.S", 32'(S), 32'h1FF);
        check("bin0.CO", 32'(CO), 32'h0);
        check("bin0.OFL", 32'(OFL), 32'h0);
        CI = 1'b1;
        @(negedge clk);
        check("bin1.S", 32'(S), 32'h000);
        check("bin1.CO", 32'(CO), 32'h1);
        check("bin1.OFL", 32'(OFL), 32'h0);

        // Boundary operands through the model.
        run_op("max_add", 9'h1FF, 9'h1FF, 1'b1, 1'b1);
        run_op("neg_sub", 9'h100, 9'h0FF, 1'b0, 1'b0);
        run_op("pos_sub", 9'h0FF, 9'h100, 1'b1, 1'b0);

        // Reset asserted mid-cycle discards the in-flight operation.
        A = 9'h055; B = 9'h0AA; CI = 1'b1; ADD = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.S", 32'(S), 32'h0);
        check("midrst.CO", 32'(CO), 32'h0);
        @(posedge clk);
        #1;
        check("midrst_edge.S", 32'(S), 32'h0);
        check("midrst_edge.OFL", 32'(OFL), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 9'h055, 9'h0AA, 1'b1, 1'b1);

        // Randomized back-to-back operations, mode changing freely every cycle.
        for (int i = 0; i < 400; i++) begin
            run_op("rand", 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
